// File: rtl/jtframe_joyscan_pkg.sv
// +----------------------------------------------------------------------------+
// | jtframe_joyscan_pkg                                                        |
// | Scan FSM state encodings and DB15 button bit positions for board remaps.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package jtframe_joyscan_pkg;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LATCH = 3'd1;
  localparam logic [2:0] S_LOW   = 3'd2;
  localparam logic [2:0] S_HIGH  = 3'd3;
  localparam logic [2:0] S_PASS  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE  = S_IDLE,
    ST_LATCH = S_LATCH,
    ST_LOW   = S_LOW,
    ST_HIGH  = S_HIGH,
    ST_PASS  = S_PASS,
    ST_DONE  = S_DONE
  } joyscan_state_e;

  // Bit positions inside a board_joy word once de-serialised
  localparam int JOY_RIGHT = 0;
  localparam int JOY_LEFT  = 1;
  localparam int JOY_DOWN  = 2;
  localparam int JOY_UP    = 3;
  localparam int JOY_B1    = 4;
  localparam int JOY_B2    = 5;
  localparam int JOY_B3    = 6;
  localparam int JOY_B4    = 7;
  localparam int JOY_B5    = 8;
  localparam int JOY_B6    = 9;
  localparam int JOY_START = 10;
  localparam int JOY_COIN  = 11;

endpackage

`default_nettype wire

// File: rtl/jtframe_joyscan_tick.sv
// +----------------------------------------------------------------------------+
// | jtframe_joyscan_tick                                                       |
// | CLKDIV divider with synchronous clear; tick is high on the last count.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module jtframe_joyscan_tick
  import jtframe_joyscan_pkg::*;
#(
  parameter int CLKDIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int            W    = $clog2(CLKDIV);
  localparam logic [W-1:0]  LAST = W'(CLKDIV - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + W'(1);
    if (clr || cnt_q == LAST) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == LAST);

endmodule

`default_nettype wire

// File: rtl/jtframe_joyscan.sv
// +----------------------------------------------------------------------------+
// | jtframe_joyscan                                                            |
// | Per-frame serial joystick scanner (latch/clock bus, up to four players).   |
// | Optional: JTFRAME_JOYSCAN_DEBOUNCE_EN publishes a word only after two      |
// | consecutive identical scans.                                               |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module jtframe_joyscan
  import jtframe_joyscan_pkg::*;
#(
  parameter int CLKDIV     = 4,
  parameter int NBITS      = 16,
  parameter int PLAYERS    = 2,
  parameter int ACTIVE_LOW = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vs,
  input  logic        scan_en,
  output logic        joy_latch,
  output logic        joy_clk,
  output logic        joy_sel,
  input  logic [1:0]  joy_din,
  output logic [15:0] board_joy1,
  output logic [15:0] board_joy2,
  output logic [15:0] board_joy3,
  output logic [15:0] board_joy4,
  output logic        joy_upd,
  output logic        busy
);

  localparam logic [3:0] LAST_BIT = 4'(NBITS - 1);
  localparam logic [1:0] INV      = (ACTIVE_LOW != 0) ? 2'b11 : 2'b00;

  joyscan_state_e state_q, state_d;
  logic        vs_q, vs_d;
  logic [3:0]  bit_q, bit_d;
  logic        half_q, half_d;
  logic        latch_q, latch_d, jclk_q, jclk_d, sel_q, sel_d;
  logic        upd_q, upd_d, busy_q, busy_d;
  logic [15:0] shadow_q [4];
  logic [15:0] shadow_d [4];
  logic [15:0] joy_q [4];
  logic [15:0] joy_d [4];
`ifdef JTFRAME_JOYSCAN_DEBOUNCE_EN
  logic [15:0] prev_q [4];
  logic [15:0] prev_d [4];
`endif
  logic trigger, tick;

  assign trigger = vs & ~vs_q & scan_en & (state_q == ST_IDLE);

  jtframe_joyscan_tick #(.CLKDIV(CLKDIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (trigger),
    .tick (tick)
  );

  always_comb begin
    state_d  = state_q;
    vs_d     = vs;
    bit_d    = bit_q;
    half_d   = half_q;
    latch_d  = latch_q;
    jclk_d   = jclk_q;
    sel_d    = sel_q;
    upd_d    = 1'b0;
    busy_d   = busy_q;
    shadow_d = shadow_q;
    joy_d    = joy_q;
`ifdef JTFRAME_JOYSCAN_DEBOUNCE_EN
    prev_d   = prev_q;
`endif
    case (state_q)
      ST_IDLE: if (trigger) begin
        state_d = ST_LATCH;
        latch_d = 1'b1;
        busy_d  = 1'b1;
        sel_d   = 1'b0;
        bit_d   = '0;
        half_d  = 1'b0;
        for (int p = 0; p < 4; p++) shadow_d[p] = '0;
      end
      ST_LATCH: if (tick) begin
        half_d = ~half_q;
        if (half_q) begin
          state_d = ST_LOW;
          latch_d = 1'b0;
          jclk_d  = 1'b0;
        end
      end
      ST_LOW: if (tick) begin
        shadow_d[{sel_q, 1'b0}][bit_q] = joy_din[0] ^ INV[0];
        shadow_d[{sel_q, 1'b1}][bit_q] = joy_din[1] ^ INV[1];
        state_d = ST_HIGH;
        jclk_d  = 1'b1;
      end
      ST_HIGH: if (tick) begin
        jclk_d = 1'b0;
        if (bit_q != LAST_BIT) begin
          bit_d   = bit_q + 4'd1;
          state_d = ST_LOW;
        end else if (PLAYERS == 4 && !sel_q) begin
          // Pass decision resolved on this tick so the second pass costs no extra cycle
          sel_d   = 1'b1;
          bit_d   = '0;
          half_d  = 1'b0;
          latch_d = 1'b1;
          state_d = ST_LATCH;
        end else begin
          state_d = ST_DONE;
          sel_d   = 1'b0;
          busy_d  = 1'b0;
`ifdef JTFRAME_JOYSCAN_DEBOUNCE_EN
          for (int p = 0; p < 4; p++) begin
            if (shadow_q[p] == prev_q[p] && joy_q[p] != shadow_q[p]) begin
              joy_d[p] = shadow_q[p];
              upd_d    = 1'b1;
            end
            prev_d[p] = shadow_q[p];
          end
`else
          joy_d = shadow_q;
          upd_d = 1'b1;
`endif
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      vs_q    <= 1'b0;
      bit_q   <= '0;
      half_q  <= 1'b0;
      latch_q <= 1'b0;
      jclk_q  <= 1'b0;
      sel_q   <= 1'b0;
      upd_q   <= 1'b0;
      busy_q  <= 1'b0;
      for (int p = 0; p < 4; p++) begin
        shadow_q[p] <= '0;
        joy_q[p]    <= '0;
`ifdef JTFRAME_JOYSCAN_DEBOUNCE_EN
        prev_q[p]   <= '0;
`endif
      end
    end else begin
      state_q <= state_d;
      vs_q    <= vs_d;
      bit_q   <= bit_d;
      half_q  <= half_d;
      latch_q <= latch_d;
      jclk_q  <= jclk_d;
      sel_q   <= sel_d;
      upd_q   <= upd_d;
      busy_q  <= busy_d;
      for (int p = 0; p < 4; p++) begin
        shadow_q[p] <= shadow_d[p];
        joy_q[p]    <= joy_d[p];
`ifdef JTFRAME_JOYSCAN_DEBOUNCE_EN
        prev_q[p]   <= prev_d[p];
`endif
      end
    end
  end

  assign joy_latch  = latch_q;
  assign joy_clk    = jclk_q;
  assign joy_sel    = sel_q;
  assign joy_upd    = upd_q;
  assign busy       = busy_q;
  assign board_joy1 = joy_q[0];
  assign board_joy2 = joy_q[1];
  assign board_joy3 = joy_q[2];
  assign board_joy4 = joy_q[3];

endmodule

`default_nettype wire

// File: doc/jtframe_joyscan.md
Name: jtframe_joyscan

Overview:
- Scan controller for serial-shift-register joysticks (DB15/SNAC-style adapters).
- Sequences latch and clock pulses on one shared serial bus and de-serialises the data lines into up to four 16-bit player words.
- Drives the board_joy1..4 inputs of the frame input block.
- Runs one complete scan per video frame, triggered by the rising edge of vs.

Parameters:
- CLKDIV, 4: clk cycles per bus half-phase; must be ≥2.
- NBITS, 16: bits shifted per player per pass; range 1..16.
- PLAYERS, 2: 2 or 4. With 4, a second pass runs with joy_sel=1 for players 3 and 4.
- ACTIVE_LOW, 1: when 1, serial data is inverted before storage so outputs are active-high.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- vs  in  1  vertical sync; a rising edge triggers a scan
- scan_en  in  1  0 = no new scans start; outputs hold their values
- joy_latch  out  1  bus latch pulse
- joy_clk  out  1  bus shift clock
- joy_sel  out  1  pass select: 0 = players 1/2, 1 = players 3/4
- joy_din  in  2  serial data; bit0 = odd player, bit1 = even player
- board_joy1..board_joy4  out  16 each  scanned words; bits at NBITS and above are 0
- joy_upd  out  1  one-cycle pulse when the outputs change
- busy  out  1  high while a scan is in progress

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0. The same applies when reset is asserted mid-scan; the partial data is discarded.
- Trigger: vs rising edge (vs registered once) with scan_en=1 and state IDLE. Edges seen while busy are ignored, never queued.
- Tick: divider counter cleared on trigger; tick when it reaches CLKDIV-1, then wraps to 0.
- States:
  - IDLE -> LATCH on trigger; joy_latch=1 and busy=1 in the cycle after the trigger.
  - LATCH lasts 2 ticks -> LOW.
  - LOW (joy_clk=0) lasts 1 tick. Both joy_din bits are sampled on the tick cycle. -> HIGH.
  - HIGH (joy_clk=1) lasts 1 tick. If the bit counter is NBITS-1 -> PASS, else increment the counter -> LOW.
  - PASS: if PLAYERS=4 and joy_sel=0, set joy_sel=1, clear the bit counter -> LATCH. Otherwise -> DONE.
  - DONE lasts one cycle: all shadow words copy to board_joy* together, joy_upd=1, joy_sel=0, busy=0 -> IDLE.
- Bit order: the first bit received lands in bit 0 and the last in bit NBITS-1 (LSB-first shift).
- Stored bit = joy_din ^ ACTIVE_LOW.
- Outputs never show partial scans; board_joy3/4 stay 0 when PLAYERS=2.
- Pass length: (2+2·NBITS)·CLKDIV cycles. joy_upd fires exactly PLAYERS/2·(2+2·NBITS)·CLKDIV+1 cycles after the trigger cycle, counting PASS/DONE transitions as zero-tick states.
- scan_en falling mid-scan: the current scan completes normally.
- vs held high: no further trigger until the next rising edge.

Optional Feature:
- Macro: JTFRAME_JOYSCAN_DEBOUNCE_EN.
- Defined: a player word is copied to its output only when two consecutive completed scans give identical values for that player. A previous-scan register is kept per player. joy_upd pulses only if at least one output changed.
- Undefined: every completed scan updates all outputs, and joy_upd pulses on every DONE.

Decomposition:
- Shared package/include: state encodings (IDLE, LATCH, LOW, HIGH, PASS, DONE) as localparams, and the DB15 button bit indices (up/down/left/right/b1..b6/start/coin) used by board-level remapping.
- One natural sub-module, jtframe_joyscan_tick: the CLKDIV divider with synchronous clear, producing a one-cycle tick.

Test Plan:
- Reset and idle: rst pulse -> all outputs 0, busy=0. A vs edge with scan_en=0 -> no joy_latch activity for 2000 cycles.
- Basic scan (CLKDIV=4, NBITS=16, PLAYERS=2): vs rise, model drives joy_din active-low for P1=16'hA5C3, P2=16'h0F01 -> exactly 16 joy_clk rises, latch high for 8 cycles, joy_upd 137 cycles after the trigger, board_joy1=16'hA5C3, board_joy2=16'h0F01.
- Four players: PLAYERS=4 with P3=16'h1234, P4=16'h8001 -> second latch with joy_sel=1, joy_upd after 273 cycles, all four words correct, joy_sel back to 0.
- Re-trigger while busy: a second vs edge mid-scan -> ignored, a single joy_upd. The next frame's edge starts a new scan.
- Reset mid-scan: rst asserted after bit 7 -> latch/clk/busy drop to 0 immediately, outputs 0. The next vs scans cleanly.
- Debounce (macro defined): P1 changes 16'h0000 -> 16'h0001 for one frame only -> board_joy1 stays 0. The same value held for two frames -> updates to 16'h0001 with a joy_upd pulse.
